// File: rtl/pwm_timebase_ctrl_if.sv
// pwm_timebase_ctrl_if
// Configuration handshake between a configuration source (master) and the
// PWM timebase (slave).
//   cfg_valid : master offers a new divide/high-time pair
//   cfg_ready : slave can accept a pair this cycle
//   cfg_div   : requested period minus 1
//   cfg_high  : requested high cycles per period
interface pwm_timebase_ctrl_if #(
  parameter int W = 8
);
  logic         cfg_valid;
  logic         cfg_ready;
  logic [W-1:0] cfg_div;
  logic [W-1:0] cfg_high;

  modport master (
    output cfg_valid,
    output cfg_div,
    output cfg_high,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_div,
    input  cfg_high,
    output cfg_ready
  );
endinterface

// File: rtl/pwm_timebase_ctrl.sv
// pwm_timebase_ctrl
// Programmable clock divider / PWM generator with glitch-free reconfiguration.
// A new divide/high-time pair only becomes active on a period boundary; an
// offer made mid-period is parked in a shadow register until the wrap.
//   clk       : single clock, rising edge
//   rst_n     : asynchronous active-low reset
//   en_i      : run enable
//   cfg       : configuration handshake (slave side)
//   clk_out_o : divided clock / PWM output
//   tick_o    : one-cycle pulse on the first cycle of each period
//   cnt_o     : current period counter
//   state_o   : 0 = IDLE, 1 = RUN, 2 = PENDING
//
// state   | meaning
// IDLE    | stopped, counter held at 0, configuration loads straight to active
// RUN     | counting with the active configuration
// PENDING | counting, a shadow configuration waits for the period wrap
module pwm_timebase_ctrl #(
  parameter int W        = 8,
  parameter int RST_DIV  = 2,
  parameter int RST_HIGH = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_i,
  pwm_timebase_ctrl_if.slave   cfg,
  output logic                 clk_out_o,
  output logic                 tick_o,
  output logic [W-1:0]         cnt_o,
  output logic [1:0]           state_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_PEND = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] act_div_q, act_div_d;
  logic [W-1:0] act_high_q, act_high_d;
  logic [W-1:0] sh_div_q, sh_div_d;
  logic [W-1:0] sh_high_q, sh_high_d;

  logic ready;
  logic xfer;
  logic at_end;

  assign ready  = (state_q != S_PEND);
  assign xfer   = cfg.cfg_valid && ready;
  assign at_end = (cnt_q == act_div_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    act_div_d  = act_div_q;
    act_high_d = act_high_q;
    sh_div_d   = sh_div_q;
    sh_high_d  = sh_high_q;

    case (state_q)
      S_RUN, S_PEND: begin
        if (!en_i) begin
          // Disable wins over everything; whatever config is newest becomes
          // active so a later re-enable starts with it.
          state_d = S_IDLE;
          cnt_d   = '0;
          if (state_q == S_PEND) begin
            act_div_d  = sh_div_q;
            act_high_d = sh_high_q;
          end else if (xfer) begin
            act_div_d  = cfg.cfg_div;
            act_high_d = cfg.cfg_high;
          end
        end else begin
          cnt_d = at_end ? '0 : cnt_q + W'(1);
          if (state_q == S_PEND) begin
            if (at_end) begin
              act_div_d  = sh_div_q;
              act_high_d = sh_high_q;
              state_d    = S_RUN;
            end
          end else if (xfer) begin
            if (at_end) begin
              // Offer lands exactly on the wrap: no need to park it.
              act_div_d  = cfg.cfg_div;
              act_high_d = cfg.cfg_high;
            end else begin
              sh_div_d  = cfg.cfg_div;
              sh_high_d = cfg.cfg_high;
              state_d   = S_PEND;
            end
          end
        end
      end
      default: begin
        cnt_d = '0;
        if (xfer) begin
          act_div_d  = cfg.cfg_div;
          act_high_d = cfg.cfg_high;
        end
        state_d = en_i ? S_RUN : S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      act_div_q  <= W'(RST_DIV);
      act_high_q <= W'(RST_HIGH);
      sh_div_q   <= W'(RST_DIV);
      sh_high_q  <= W'(RST_HIGH);
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      act_div_q  <= act_div_d;
      act_high_q <= act_high_d;
      sh_div_q   <= sh_div_d;
      sh_high_q  <= sh_high_d;
    end
  end

  // Outputs depend on registered state only, so reset forces them at once.
  assign cfg.cfg_ready = ready;
  assign clk_out_o     = (state_q != S_IDLE) && (cnt_q < act_high_q);
  assign tick_o        = (state_q != S_IDLE) && (cnt_q == '0);
  assign cnt_o         = cnt_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_pwm_timebase_ctrl.sv
// tb_pwm_timebase_ctrl
// Directed scenarios with literal expectations, followed by a randomized run.
// A behavioural model (run flag, period position, active pair, queue of at
// most one parked pair) is checked against the DUT on every falling edge.
module tb_pwm_timebase_ctrl;
  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         en    = 1'b0;
  logic         clk_out;
  logic         tick;
  logic [W-1:0] cnt;
  logic [1:0]   state;

  pwm_timebase_ctrl_if #(.W(W)) cfg_if ();

  pwm_timebase_ctrl #(.W(W), .RST_DIV(2), .RST_HIGH(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (en),
    .cfg       (cfg_if),
    .clk_out_o (clk_out),
    .tick_o    (tick),
    .cnt_o     (cnt),
    .state_o   (state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  task automatic offer(input int d, input int h);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_div   = d[W-1:0];
    cfg_if.cfg_high  = h[W-1:0];
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // ---------------- behavioural model ----------------
  int m_run  = 0;
  int m_pos  = 0;
  int m_div  = 2;
  int m_high = 1;
  int q_div[$];
  int q_high[$];
  bit m_x, m_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_pos = 0; m_div = 2; m_high = 1;
      q_div.delete(); q_high.delete();
    end else begin
      m_x = cfg_if.cfg_valid && (q_div.size() == 0);
      m_b = (m_pos == m_div);
      if (m_run == 0) begin
        if (m_x) begin m_div = int'(cfg_if.cfg_div); m_high = int'(cfg_if.cfg_high); end
        if (en) begin m_run = 1; m_pos = 0; end
      end else if (!en) begin
        m_run = 0; m_pos = 0;
        if (q_div.size() != 0) begin
          m_div = q_div.pop_front(); m_high = q_high.pop_front();
        end else if (m_x) begin
          m_div = int'(cfg_if.cfg_div); m_high = int'(cfg_if.cfg_high);
        end
      end else begin
        m_pos = (m_pos + 1) % (m_div + 1);
        if (m_b && q_div.size() != 0) begin
          m_div = q_div.pop_front(); m_high = q_high.pop_front();
        end
        if (m_x) begin
          if (m_b) begin
            m_div = int'(cfg_if.cfg_div); m_high = int'(cfg_if.cfg_high);
          end else begin
            q_div.push_back(int'(cfg_if.cfg_div)); q_high.push_back(int'(cfg_if.cfg_high));
          end
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    int es;
    es = (m_run == 0) ? 0 : ((q_div.size() != 0) ? 2 : 1);
    chk("m_state",   int'(state),            es);
    chk("m_cnt",     int'(cnt),              m_pos);
    chk("m_clk_out", int'(clk_out),          int'(m_run != 0 && m_pos < m_high));
    chk("m_tick",    int'(tick),             int'(m_run != 0 && m_pos == 0));
    chk("m_ready",   int'(cfg_if.cfg_ready), int'(q_div.size() == 0));
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] rd, rh;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_div   = '0;
    cfg_if.cfg_high  = '0;
    repeat (2) cyc();
    rst_n = 1'b1;
    chk("rst_state",   int'(state), 0);
    chk("rst_cnt",     int'(cnt), 0);
    chk("rst_clk_out", int'(clk_out), 0);
    chk("rst_tick",    int'(tick), 0);
    chk("rst_ready",   int'(cfg_if.cfg_ready), 1);

    // defaults: period 3, high 1
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("def_cnt",     int'(cnt), i % 3);
      chk("def_clk_out", int'(clk_out), int'(i % 3 == 0));
      chk("def_tick",    int'(tick), int'(i % 3 == 0));
    end

    // reconfigure mid-period -> PENDING until wrap
    cyc();
    offer(4, 2);
    cyc();
    cfg_if.cfg_valid = 1'b0;
    chk("pend_state", int'(state), 2);
    chk("pend_ready", int'(cfg_if.cfg_ready), 0);
    chk("pend_cnt",   int'(cnt), 1);
    cyc();
    chk("pend_state2", int'(state), 2);
    chk("pend_ready2", int'(cfg_if.cfg_ready), 0);
    cyc();
    chk("apply_state", int'(state), 1);
    chk("apply_ready", int'(cfg_if.cfg_ready), 1);
    for (int i = 0; i < 10; i++) begin
      chk("p5_cnt",     int'(cnt), i % 5);
      chk("p5_clk_out", int'(clk_out), int'(i % 5 < 2));
      chk("p5_tick",    int'(tick), int'(i % 5 == 0));
      cyc();
    end

    // offer exactly at the boundary -> stays RUN
    repeat (4) cyc();
    chk("bnd_pre_cnt", int'(cnt), 4);
    offer(5, 3);
    cyc();
    cfg_if.cfg_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("bnd_state",   int'(state), 1);
      chk("bnd_cnt",     int'(cnt), i);
      chk("bnd_clk_out", int'(clk_out), int'(i < 3));
      cyc();
    end

    // disable while PENDING -> shadow becomes active
    offer(3, 1);
    cyc();
    cfg_if.cfg_valid = 1'b0;
    chk("dis_pend_state", int'(state), 2);
    en = 1'b0;
    cyc();
    chk("dis_state",   int'(state), 0);
    chk("dis_cnt",     int'(cnt), 0);
    chk("dis_clk_out", int'(clk_out), 0);
    chk("dis_tick",    int'(tick), 0);
    chk("dis_ready",   int'(cfg_if.cfg_ready), 1);
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("reen_cnt",     int'(cnt), i % 4);
      chk("reen_clk_out", int'(clk_out), int'(i % 4 < 1));
    end

    // extremes
    en = 1'b0;
    offer(0, 1);
    cyc();
    cfg_if.cfg_valid = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("div0_tick",    int'(tick), 1);
      chk("div0_clk_out", int'(clk_out), 1);
      chk("div0_cnt",     int'(cnt), 0);
    end
    offer(0, 0);
    cyc();
    cfg_if.cfg_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("high0_clk_out", int'(clk_out), 0);
      chk("high0_tick",    int'(tick), 1);
      cyc();
    end
    offer(3, 255);
    cyc();
    cfg_if.cfg_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("high255_clk_out", int'(clk_out), 1);
      chk("high255_cnt",     int'(cnt), i % 4);
      if (i < 7) cyc();
    end

    // asynchronous reset at CNT=3 while PENDING
    cyc();
    offer(6, 2);
    cyc();
    cfg_if.cfg_valid = 1'b0;
    repeat (2) cyc();
    chk("ar_pre_state", int'(state), 2);
    chk("ar_pre_cnt",   int'(cnt), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_state",   int'(state), 0);
    chk("ar_cnt",     int'(cnt), 0);
    chk("ar_clk_out", int'(clk_out), 0);
    chk("ar_tick",    int'(tick), 0);
    chk("ar_ready",   int'(cfg_if.cfg_ready), 1);
    en = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("ar_idle_wait", int'(state), 0);
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("ar_def_cnt",     int'(cnt), i % 3);
      chk("ar_def_clk_out", int'(clk_out), int'(i % 3 == 0));
    end

    // randomized phase; offers are held while not ready
    for (int i = 0; i < 3000; i++) begin
      cyc();
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
      end
      en = ($urandom_range(0, 15) != 0);
      if (!(cfg_if.cfg_valid && !cfg_if.cfg_ready)) begin
        rd = 8'($urandom);
        rh = 8'($urandom);
        if ($urandom_range(0, 7) != 0) rd = {5'b0, rd[2:0]};
        if ($urandom_range(0, 7) != 0) rh = {4'b0, rh[3:0]};
        cfg_if.cfg_valid = ($urandom_range(0, 3) == 0);
        cfg_if.cfg_div   = rd;
        cfg_if.cfg_high  = rh;
      end
    end
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
